// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular trace of write-back retirements, frozen on stop for stepped review.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [7:0]    wb_instr,
  input  logic          wb_rfwrite,
  input  logic [1:0]    wb_regw,
  input  logic [7:0]    wb_data,
  input  logic          stop,
  input  logic          freeze_req,
  input  logic          clear,
  input  logic          step_next,
  input  logic          step_prev,
  output logic [7:0]    rd_instr,
  output logic [7:0]    rd_data,
  output logic [1:0]    rd_regw,
  output logic          rd_rfwrite,
  output logic [AW-1:0] rd_index,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          frozen
);
  typedef enum logic {CAPTURE, FROZEN} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state, state_nxt;
  logic [18:0] mem [DEPTH];
  logic [AW-1:0] wp, wp_nxt, age, age_nxt, newest, last, rd_addr;
  logic [AW:0] cnt_nxt, cnt_dec;
  logic wr, ovf_nxt;
  always_comb begin
    wr        = !clear && state == CAPTURE && wb_valid;
    state_nxt = clear ? CAPTURE : (stop || freeze_req) ? FROZEN : state;
    cnt_nxt   = clear ? '0 : (wr && count != FULL) ? count + (AW+1)'(1) : count;
    wp_nxt    = clear ? '0 : wr ? wp + AW'(1) : wp;
    ovf_nxt   = !clear && (overflow || (wr && count == FULL));
    cnt_dec   = cnt_nxt - (AW+1)'(1);
    newest    = cnt_nxt == '0 ? '0 : cnt_dec[AW-1:0];
    last      = count[AW-1:0] - AW'(1);
    // age is the display position relative to the oldest held entry
    age_nxt   = clear ? '0 :
                state == CAPTURE ? newest :
                (count == '0 || step_next == step_prev) ? age :
                step_next ? (age == last ? '0 : age + AW'(1)) :
                (age == '0 ? last : age - AW'(1));
    rd_addr   = wp - count[AW-1:0] + age;
  end
  always_ff @(posedge clock)
    if (wr) mem[wp] <= {wb_instr, wb_rfwrite, wb_regw, wb_data};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= CAPTURE;
      wp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      age      <= '0;
      {rd_instr, rd_rfwrite, rd_regw, rd_data} <= '0;
      rd_index <= '0;
    end else begin
      state    <= state_nxt;
      wp       <= wp_nxt;
      count    <= cnt_nxt;
      overflow <= ovf_nxt;
      age      <= age_nxt;
      {rd_instr, rd_rfwrite, rd_regw, rd_data} <= count == '0 ? '0 : mem[rd_addr];
      rd_index <= count == '0 ? '0 : age;
    end
  assign frozen = state == FROZEN;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed checks of capture, overflow, freeze/step review, clear and async reset.
module tb_wb_trace_buffer;
  logic clock = 1'b0, reset = 1'b1;
  logic wb_valid = 1'b0, wb_rfwrite = 1'b0;
  logic [7:0] wb_instr = '0, wb_data = '0;
  logic [1:0] wb_regw = '0;
  logic stop = 1'b0, freeze_req = 1'b0, clear = 1'b0, step_next = 1'b0, step_prev = 1'b0;
  logic [7:0] rd_instr, rd_data;
  logic [1:0] rd_regw;
  logic rd_rfwrite, overflow, frozen;
  logic [3:0] rd_index;
  logic [4:0] count;
  int checks = 0, errors = 0;

  wb_trace_buffer #(.DEPTH(16), .AW(4)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .wb_rfwrite(wb_rfwrite), .wb_regw(wb_regw), .wb_data(wb_data), .stop(stop),
    .freeze_req(freeze_req), .clear(clear), .step_next(step_next), .step_prev(step_prev),
    .rd_instr(rd_instr), .rd_data(rd_data), .rd_regw(rd_regw), .rd_rfwrite(rd_rfwrite),
    .rd_index(rd_index), .count(count), .overflow(overflow), .frozen(frozen)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [7:0] instr, input logic [7:0] data);
    wb_valid = 1'b1; wb_instr = instr; wb_data = data;
    wb_rfwrite = 1'b1; wb_regw = instr[1:0];
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_instr", 32'(rd_instr), 0);
    reset = 1'b0;
    tick();
    // three retirements
    retire(8'h41, 8'h05); retire(8'h52, 8'h06); retire(8'h63, 8'h07);
    chk("t1_count", 32'(count), 3);
    chk("t1_ovf", 32'(overflow), 0);
    tick();
    chk("t1_instr", 32'(rd_instr), 32'h63);
    chk("t1_data", 32'(rd_data), 32'h07);
    chk("t1_regw", 32'(rd_regw), 3);
    chk("t1_rfw", 32'(rd_rfwrite), 1);
    chk("t1_index", 32'(rd_index), 2);
    pulse_clear();
    chk("clr_count", 32'(count), 0);
    // wrap past DEPTH
    for (int i = 0; i < 18; i++) retire(8'h80 + 8'(i), 8'(i));
    chk("t2_count", 32'(count), 16);
    chk("t2_ovf", 32'(overflow), 1);
    freeze_req = 1'b1; tick(); freeze_req = 1'b0;
    chk("t2_frozen", 32'(frozen), 1);
    tick();
    chk("t2_newest_idx", 32'(rd_index), 15);
    chk("t2_newest_data", 32'(rd_data), 32'h11);
    step_next = 1'b1; tick(); step_next = 1'b0; tick();
    chk("t2_wrap_data", 32'(rd_data), 32'h02);
    chk("t2_wrap_idx", 32'(rd_index), 0);
    // clear beats stop and wb_valid
    clear = 1'b1; stop = 1'b1; wb_valid = 1'b1; wb_instr = 8'h99; wb_data = 8'h99;
    tick();
    clear = 1'b0; wb_valid = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_frozen0", 32'(frozen), 0);
    tick();
    chk("t5_frozen1", 32'(frozen), 1);
    chk("t5_count2", 32'(count), 0);
    chk("t5_data", 32'(rd_data), 0);
    chk("t5_instr", 32'(rd_instr), 0);
    chk("t5_index", 32'(rd_index), 0);
    stop = 1'b0;
    pulse_clear();
    // stop with a retiring instruction
    stop = 1'b1; wb_valid = 1'b1; wb_instr = 8'h01; wb_data = 8'hAA; wb_regw = 2'd1; wb_rfwrite = 1'b1;
    tick();
    stop = 1'b0; wb_valid = 1'b0;
    chk("t3_frozen", 32'(frozen), 1);
    chk("t3_count", 32'(count), 1);
    tick();
    chk("t3_data", 32'(rd_data), 32'hAA);
    chk("t3_instr", 32'(rd_instr), 32'h01);
    pulse_clear();
    // four-entry review
    for (int i = 0; i < 4; i++) retire(8'h10 + 8'(i), 8'h20 + 8'(i));
    freeze_req = 1'b1; tick(); freeze_req = 1'b0; tick();
    chk("t4_idx_newest", 32'(rd_index), 3);
    step_next = 1'b1; tick(); step_next = 1'b0; tick();
    chk("t4_idx_oldest", 32'(rd_index), 0);
    chk("t4_data_oldest", 32'(rd_data), 32'h20);
    step_prev = 1'b1; tick(); step_prev = 1'b0; tick();
    chk("t4_prev_wrap", 32'(rd_index), 3);
    chk("t4_prev_data", 32'(rd_data), 32'h23);
    step_next = 1'b1; step_prev = 1'b1; tick(); step_next = 1'b0; step_prev = 1'b0; tick();
    chk("t4_both", 32'(rd_index), 3);
    wb_valid = 1'b1; tick(); tick(); wb_valid = 1'b0;
    chk("t4_count_hold", 32'(count), 4);
    step_prev = 1'b1; tick(); step_prev = 1'b0; tick();
    chk("t6_idx", 32'(rd_index), 2);
    chk("t6_instr_pre", 32'(rd_instr), 32'h12);
    // async reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("t6_instr", 32'(rd_instr), 0);
    chk("t6_data", 32'(rd_data), 0);
    chk("t6_regw", 32'(rd_regw), 0);
    chk("t6_rfw", 32'(rd_rfwrite), 0);
    chk("t6_index", 32'(rd_index), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_frozen", 32'(frozen), 0);
    #1 reset = 1'b0;
    tick();
    retire(8'h77, 8'h55);
    chk("t6_resume_count", 32'(count), 1);
    chk("t6_resume_frozen", 32'(frozen), 0);
    tick();
    chk("t6_resume_data", 32'(rd_data), 32'h55);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
